// File: rtl/banco_fifos_salida_pkg.sv
// banco_fifos_salida_pkg: shared widths, thresholds and entry-field layout
// for the output FIFO bank and the upstream arbiter.
package banco_fifos_salida_pkg;
   localparam int DATA_W_DEF    = 6;
   localparam int DEPTH_DEF     = 8;
   localparam int UMBRAL_AF_DEF = 2;
   localparam int N_FIFOS       = 4;
   localparam int CLASE_MSB     = 5;
   localparam int CLASE_LSB     = 4;
   localparam int PAYLOAD_MSB   = 3;
   localparam int PAYLOAD_LSB   = 0;
   function automatic logic es_onehot(input logic [N_FIFOS-1:0] v);
      return (v != '0) && ((v & (v - {{(N_FIFOS-1){1'b0}}, 1'b1})) == '0);
   endfunction
endpackage

// File: rtl/banco_fifos_salida_fifo_simple.sv
// fifo_simple: one output FIFO with registered read port, occupancy flags
// and a sticky protocol-violation flag.
module fifo_simple #(
   parameter int DATA_W    = 6,
   parameter int DEPTH     = 8,
   parameter int UMBRAL_AF = 2
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [DATA_W-1:0] data_in,
   input  logic              push,
   input  logic              pop,
   input  logic              push_bad,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              almost_full,
   output logic              fifo_empty,
   output logic              fifo_full,
   output logic              error
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LLENO  = (AW+1)'(DEPTH);
   localparam logic [AW:0] UMBRAL = (AW+1)'(UMBRAL_AF);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]       cnt_q, cnt_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              valid_q, valid_d, err_q, err_d, wr_en, rd_en;
   always_comb begin
      fifo_empty  = cnt_q == '0;
      fifo_full   = cnt_q == LLENO;
      almost_full = (LLENO - cnt_q) <= UMBRAL;
      wr_en       = push && !fifo_full;
      rd_en       = pop && !fifo_empty;
      wr_d        = wr_en ? wr_q + AW'(1) : wr_q;
      rd_d        = rd_en ? rd_q + AW'(1) : rd_q;
      cnt_d       = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      dout_d      = rd_en ? mem_q[rd_q] : dout_q;
      valid_d     = rd_en;
      err_d       = err_q | (push && fifo_full) | (pop && fifo_empty) | push_bad;
   end
   // storage is never reset: entries are only readable after being rewritten
   always_ff @(posedge clk)
      if (wr_en) mem_q[wr_q] <= data_in;
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end
   assign data_out  = dout_q;
   assign valid_out = valid_q;
   assign error     = err_q;
endmodule

// File: rtl/banco_fifos_salida.sv
// banco_fifos_salida: bank of four independent output FIFOs fed by a one-hot
// push from the arbiter and drained by per-FIFO consumers.
module banco_fifos_salida
   import banco_fifos_salida_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int UMBRAL_AF = UMBRAL_AF_DEF
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [DATA_W-1:0] data_in,
   input  logic [3:0]        Push,
   input  logic [3:0]        Pop,
   output logic [DATA_W-1:0] data_out0,
   output logic [DATA_W-1:0] data_out1,
   output logic [DATA_W-1:0] data_out2,
   output logic [DATA_W-1:0] data_out3,
   output logic [3:0]        valid_out,
   output logic [3:0]        Almost_full,
   output logic [3:0]        FIFO_empty,
   output logic [3:0]        FIFO_full,
   output logic [3:0]        error
);
   logic [3:0]        push_ok, push_bad;
   logic [DATA_W-1:0] dout [N_FIFOS];
   // a multi-hot push writes nowhere and flags every FIFO it addressed
   always_comb begin
      push_ok  = es_onehot(Push) ? Push : '0;
      push_bad = es_onehot(Push) ? '0 : Push;
   end
   for (genvar i = 0; i < N_FIFOS; i++) begin : g_fifo
      fifo_simple #(
         .DATA_W   (DATA_W),
         .DEPTH    (DEPTH),
         .UMBRAL_AF(UMBRAL_AF)
      ) u_fifo (
         .clk        (clk),
         .reset_L    (reset_L),
         .data_in    (data_in),
         .push       (push_ok[i]),
         .pop        (Pop[i]),
         .push_bad   (push_bad[i]),
         .data_out   (dout[i]),
         .valid_out  (valid_out[i]),
         .almost_full(Almost_full[i]),
         .fifo_empty (FIFO_empty[i]),
         .fifo_full  (FIFO_full[i]),
         .error      (error[i])
      );
   end
   assign data_out0 = dout[0];
   assign data_out1 = dout[1];
   assign data_out2 = dout[2];
   assign data_out3 = dout[3];
endmodule

// File: tb/tb_banco_fifos_salida.sv
// tb_banco_fifos_salida: queue-based reference model with a negedge scoreboard
// monitor; directed scenarios followed by randomized traffic.
module tb_banco_fifos_salida;
   localparam int DW = 6;
   localparam int D  = 8;
   localparam int AF = 2;
   logic          clk = 1'b0;
   logic          reset_L = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [3:0]    Push = '0, Pop = '0;
   logic [DW-1:0] data_out0, data_out1, data_out2, data_out3;
   logic [3:0]    valid_out, Almost_full, FIFO_empty, FIFO_full, error;
   always #5 clk = ~clk;
   banco_fifos_salida #(.DATA_W(DW), .DEPTH(D), .UMBRAL_AF(AF)) dut (
      .clk(clk), .reset_L(reset_L), .data_in(data_in), .Push(Push), .Pop(Pop),
      .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
      .valid_out(valid_out), .Almost_full(Almost_full), .FIFO_empty(FIFO_empty),
      .FIFO_full(FIFO_full), .error(error)
   );
   logic [DW-1:0] fifo_m [4][$];
   logic [DW-1:0] exp_q  [4][$];
   logic [DW-1:0] last_m [4];
   logic [3:0]    err_m = '0;
   int            n_chk = 0, n_fail = 0;
   bit            mon_en = 1'b0;
   function automatic logic [DW-1:0] dout(input int i);
      return i == 0 ? data_out0 : i == 1 ? data_out1 : i == 2 ? data_out2 : data_out3;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask
   task automatic clear_model();
      for (int i = 0; i < 4; i++) begin
         fifo_m[i].delete();
         exp_q[i].delete();
         last_m[i] = '0;
      end
      err_m = '0;
   endtask
   // model: effect of one clock edge given the pre-edge occupancy
   task automatic apply(input logic [3:0] pu, input logic [3:0] po, input logic [DW-1:0] d);
      bit oh = $onehot(pu);
      for (int i = 0; i < 4; i++) begin
         bit was_empty = fifo_m[i].size() == 0;
         bit was_full  = fifo_m[i].size() == D;
         if (po[i]) begin
            if (was_empty) err_m[i] = 1'b1;
            else exp_q[i].push_back(fifo_m[i].pop_front());
         end
         if (pu[i]) begin
            if (!oh || was_full) err_m[i] = 1'b1;
            else fifo_m[i].push_back(d);
         end
      end
   endtask
   task automatic step(input logic [3:0] pu, input logic [3:0] po, input logic [DW-1:0] d);
      Push = pu;
      Pop = po;
      data_in = d;
      @(posedge clk);
      apply(pu, po, d);
      #1;
   endtask
   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_empty"}, FIFO_empty, 4'b1111);
      chk({tag, "_full"}, FIFO_full, 4'b0000);
      chk({tag, "_af"}, Almost_full, 4'b0000);
      chk({tag, "_valid"}, valid_out, 4'b0000);
      chk({tag, "_error"}, error, 4'b0000);
      chk({tag, "_dout"}, {data_out0, data_out1, data_out2, data_out3}, '0);
   endtask
   // half-cycle low pulse starting just after a rising edge
   task automatic pulse_reset();
      Push = '0;
      Pop = '0;
      reset_L = 1'b0;
      clear_model();
      #1;
      chk_reset_outputs("mid_reset");
      @(negedge clk);
      #1 reset_L = 1'b1;
   endtask
   always @(negedge clk) begin
      logic [3:0] e, f, a;
      logic [DW-1:0] x;
      bit ev;
      if (mon_en) begin
         for (int i = 0; i < 4; i++) begin
            e[i] = fifo_m[i].size() == 0;
            f[i] = fifo_m[i].size() == D;
            a[i] = (D - fifo_m[i].size()) <= AF;
         end
         chk("FIFO_empty", FIFO_empty, e);
         chk("FIFO_full", FIFO_full, f);
         chk("Almost_full", Almost_full, a);
         chk("error", error, err_m);
         for (int i = 0; i < 4; i++) begin
            ev = exp_q[i].size() != 0;
            chk($sformatf("valid_out%0d", i), valid_out[i], ev);
            if (ev) begin
               x = exp_q[i].pop_front();
               chk($sformatf("data_out%0d", i), dout(i), x);
               last_m[i] = x;
            end else chk($sformatf("data_out%0d_hold", i), dout(i), last_m[i]);
         end
      end
   end
   initial begin
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      reset_L = 1'b1;
      mon_en = 1'b1;
      // three pushes into FIFO 0
      step(4'b0001, 4'b0000, 6'h11);
      step(4'b0001, 4'b0000, 6'h12);
      step(4'b0001, 4'b0000, 6'h13);
      chk("three_push_empty", FIFO_empty, 4'b1110);
      chk("three_push_af", Almost_full, 4'b0000);
      // fill FIFO 2 past its threshold and beyond full
      for (int k = 0; k < 6; k++) step(4'b0100, 4'b0000, DW'(6'h20 + k));
      chk("six_push_af", Almost_full, 4'b0100);
      for (int k = 6; k < 8; k++) step(4'b0100, 4'b0000, DW'(6'h20 + k));
      chk("eight_push_full", FIFO_full, 4'b0100);
      step(4'b0100, 4'b0000, 6'h3f);
      chk("ninth_push_error", error, 4'b0100);
      chk("ninth_push_full", FIFO_full, 4'b0100);
      // FIFO 1 order and pointer wrap
      for (int k = 0; k < 8; k++) step(4'b0010, 4'b0000, DW'(k));
      for (int k = 0; k < 8; k++) step(4'b0000, 4'b0010, '0);
      for (int k = 0; k < 3; k++) step(4'b0010, 4'b0000, DW'(6'h30 + k));
      for (int k = 0; k < 3; k++) step(4'b0000, 4'b0010, '0);
      step(4'b0000, 4'b0000, '0);
      chk("wrap_empty1", FIFO_empty[1], 1'b1);
      chk("wrap_dout1", data_out1, 6'h32);
      // concurrent push and pop on FIFO 3
      step(4'b1000, 4'b0000, 6'h0a);
      step(4'b1000, 4'b0000, 6'h0b);
      step(4'b1000, 4'b1000, 6'h0c);
      chk("pushpop_valid", valid_out, 4'b1000);
      chk("pushpop_dout3", data_out3, 6'h0a);
      chk("pushpop_count", fifo_m[3].size(), 2);
      // pop on empty with a multi-hot push
      pulse_reset();
      step(4'b0110, 4'b0001, 6'h15);
      chk("multihot_error", error, 4'b0111);
      chk("multihot_empty", FIFO_empty, 4'b1111);
      // reset while FIFO 0 is partly full
      pulse_reset();
      for (int k = 0; k < 4; k++) step(4'b0001, 4'b0000, DW'(6'h2a + k));
      chk("pre_reset_empty", FIFO_empty, 4'b1110);
      pulse_reset();
      step(4'b0000, 4'b0001, '0);
      chk("post_reset_pop_error", error, 4'b0001);
      // randomized traffic, reset between blocks so errors stay informative
      for (int b = 0; b < 4; b++) begin
         pulse_reset();
         for (int k = 0; k < 150; k++) begin
            int r = $urandom_range(0, 9);
            logic [3:0] pu, po;
            pu = r < 6 ? 4'(1 << $urandom_range(0, 3)) : r < 8 ? 4'b0000 : 4'($urandom);
            for (int i = 0; i < 4; i++) po[i] = $urandom_range(0, 99) < 30;
            step(pu, po, DW'($urandom));
         end
      end
      step(4'b0000, 4'b0000, '0);
      step(4'b0000, 4'b0000, '0);
      mon_en = 1'b0;
      for (int i = 0; i < 4; i++) chk($sformatf("pending_pops%0d", i), exp_q[i].size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/banco_fifos_salida.md
BANCO_FIFOS_SALIDA -- requirements
Module: banco_fifos_salida

Interface
REQ-001 SHALL have parameter DATA_W, default 6, width of one entry ({class[1:0], payload[3:0]}).
REQ-002 SHALL have parameter DEPTH, default 8, entries per FIFO (power of two).
REQ-003 SHALL have parameter UMBRAL_AF, default 2, free-entry count at or below which Almost_full asserts.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on posedge clk.
REQ-005 SHALL have port reset_L, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port data_in, input, DATA_W, entry presented by the upstream arbiter.
REQ-007 SHALL have port Push, input, 4, one-hot write strobe selecting destination FIFO 0..3.
REQ-008 SHALL have port Pop, input, 4, per-FIFO read strobe from downstream consumers.
REQ-009 SHALL have ports data_out0..data_out3, output, DATA_W each, registered read data per FIFO.
REQ-010 SHALL have port valid_out, output, 4, bit i high for one cycle when data_out_i carries a popped entry.
REQ-011 SHALL have port Almost_full, output, 4, per-FIFO backpressure to the arbiter.
REQ-012 SHALL have port FIFO_empty, output, 4, per-FIFO empty flag.
REQ-013 SHALL have port FIFO_full, output, 4, per-FIFO full flag.
REQ-014 SHALL have port error, output, 4, sticky per-FIFO protocol-violation flag.

Function
REQ-015 Each FIFO SHALL hold a write pointer, read pointer (log2(DEPTH) bits, wrapping DEPTH-1 -> 0) and occupancy count (log2(DEPTH)+1 bits).
REQ-016 Push[i]=1 with FIFO i not full SHALL write data_in at wr_ptr_i and increment wr_ptr_i at that edge.
REQ-017 Pop[i]=1 with FIFO i not empty SHALL load data_out_i from rd_ptr_i, set valid_out[i] next cycle, increment rd_ptr_i (1-cycle read latency).
REQ-018 data_out_i SHALL hold its last value when no valid pop occurs; valid_out[i] SHALL be 0.
REQ-019 Simultaneous valid Push[i] and Pop[i] SHALL leave count_i unchanged; both pointers advance.
REQ-020 Push[i] and Pop[i] on an empty FIFO SHALL perform the write only; the pop is ignored and error[i] set.
REQ-021 Push[i] on a full FIFO SHALL be dropped, contents unchanged, error[i] set; a same-cycle Pop[i] SHALL still complete.
REQ-022 Pop[i] on an empty FIFO SHALL be ignored and set error[i].
REQ-023 Push with more than one bit set SHALL write no FIFO and set error bits for every FIFO addressed.
REQ-024 FIFO_empty[i] SHALL equal (count_i==0); FIFO_full[i] SHALL equal (count_i==DEPTH); both decoded from registered count.
REQ-025 Almost_full[i] SHALL equal (DEPTH-count_i <= UMBRAL_AF), registered-count based, no extra latency.
REQ-026 error bits SHALL remain set until reset.
REQ-027 The four FIFOs SHALL operate independently; activity on one never alters another's state.

Reset
REQ-028 reset_L=0 SHALL immediately clear all pointers, counts, data_out0..3, valid_out, error, Almost_full, FIFO_full, and force FIFO_empty=4'b1111.
REQ-029 Storage array contents SHALL NOT require reset; they are unreadable until rewritten.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; first edge after release behaves as empty state.

Structure
REQ-031 A shared package SHALL hold DATA_W, DEPTH, UMBRAL_AF defaults and the class field position constants, shared with the arbiter.
REQ-032 One sub-module fifo_simple (single FIFO, same ports in scalar form) SHALL be instantiated four times.

Verification
REQ-033 Reset then Push=0001 with data_in 6'h11,6'h12,6'h13 -> count0=3, FIFO_empty=1110, Almost_full=0000.
REQ-034 Six pushes to FIFO 2 (DEPTH 8, UMBRAL_AF 2) -> Almost_full=0100 after 6th edge; two more -> FIFO_full=0100; ninth push -> dropped, error=0100.
REQ-035 Fill FIFO 1 with 8'h.. sequence 0..7, pop 8 times, push 3, pop 3 -> data_out1 order 0..7 then new values, pointers wrapped, FIFO_empty[1]=1.
REQ-036 FIFO 3 holding 2 entries, Push=1000 and Pop=1000 same cycle -> count3 stays 2, oldest entry on data_out3 with valid_out=1000.
REQ-037 Pop=0001 on empty FIFO 0 and Push=0110 -> no writes, error=0111, all counts unchanged.
REQ-038 reset_L low for one half-cycle while FIFO 0 holds 4 entries -> outputs cleared immediately, FIFO_empty=1111, next pop sets error[0].
